// File: rtl/ysyx_25040109_axi_arbiter.sv
// rtl/ysyx_25040109_axi_arbiter.sv - IFU/LSU to single-slave AXI arbiter, one outstanding transaction
// Round-robin between masters; inside the LSU a pending write beats a pending read.
module ysyx_25040109_axi_arbiter #(
  parameter logic [3:0] IFU_ID         = 4'd0,
  parameter logic [3:0] LSU_ID         = 4'd1,
  parameter logic       FIRST_PRIO_LSU = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [31:0] ifu_araddr,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rlast,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  input  logic [31:0] lsu_araddr,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rlast,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_awaddr,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  output logic [1:0]  lsu_bresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arid,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic [3:0]  m_rid,
  input  logic        m_rlast,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp
);

  typedef enum logic [2:0] {IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_WR, LSU_B} state_t;

  state_t state, state_nxt;
  logic   rr_last, rr_last_nxt;  // 1: LSU was the master served last
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;
  logic   lsu_req, aw_fire, w_fire;
  logic   unused_rid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= ~FIRST_PRIO_LSU;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    lsu_req     = lsu_awvalid | lsu_arvalid;
    case (state)
      IDLE: begin
        if (ifu_arvalid && (!lsu_req || rr_last)) begin
          state_nxt   = IFU_AR;
          rr_last_nxt = 1'b0;
        end else if (lsu_req) begin
          state_nxt   = lsu_awvalid ? LSU_WR : LSU_AR;
          rr_last_nxt = 1'b1;
        end
      end
      IFU_AR: begin
        m_arvalid   = ifu_arvalid;
        ifu_arready = m_arready;
        if (!ifu_arvalid)   state_nxt = IDLE;
        else if (m_arready) state_nxt = IFU_R;
      end
      IFU_R: begin
        ifu_rvalid = m_rvalid;
        m_rready   = ifu_rready;
        if (m_rvalid && ifu_rready && m_rlast) state_nxt = IDLE;
      end
      LSU_AR: begin
        m_arvalid   = lsu_arvalid;
        lsu_arready = m_arready;
        if (!lsu_arvalid)   state_nxt = IDLE;
        else if (m_arready) state_nxt = LSU_R;
      end
      LSU_R: begin
        lsu_rvalid = m_rvalid;
        m_rready   = lsu_rready;
        if (m_rvalid && lsu_rready && m_rlast) state_nxt = IDLE;
      end
      LSU_WR: begin
        // done flags keep a held valid from issuing a second handshake
        m_awvalid   = lsu_awvalid & ~aw_done;
        lsu_awready = m_awready & ~aw_done;
        m_wvalid    = lsu_wvalid & ~w_done;
        lsu_wready  = m_wready & ~w_done;
        aw_fire     = m_awvalid & m_awready;
        w_fire      = m_wvalid & m_wready;
        if (aw_fire) aw_done_nxt = 1'b1;
        if (w_fire)  w_done_nxt  = 1'b1;
        if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = LSU_B;
      end
      LSU_B: begin
        lsu_bvalid = m_bvalid;
        m_bready   = lsu_bready;
        if (m_bvalid && lsu_bready) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_araddr   = (state == LSU_AR) ? lsu_araddr : ifu_araddr;
  assign m_arid     = (state == LSU_AR) ? LSU_ID : IFU_ID;
  assign m_awaddr   = lsu_awaddr;
  assign m_wdata    = lsu_wdata;
  assign m_wstrb    = lsu_wstrb;
  assign ifu_rdata  = m_rdata;
  assign ifu_rresp  = m_rresp;
  assign ifu_rlast  = m_rlast;
  assign lsu_rdata  = m_rdata;
  assign lsu_rresp  = m_rresp;
  assign lsu_rlast  = m_rlast;
  assign lsu_bresp  = m_bresp;
  // the single-outstanding rule makes the grant, not the ID, the routing key
  assign unused_rid = ^m_rid;

endmodule

// File: tb/tb_ysyx_25040109_axi_arbiter.sv
// tb/tb_ysyx_25040109_axi_arbiter.sv - randomized bench for the IFU/LSU AXI arbiter
// A transaction-order model (round-robin, write-before-read) predicts which master is served next.
module tb_ysyx_25040109_axi_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic [1:0]  lsu_bresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [1:0]  m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;

  ysyx_25040109_axi_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .lsu_bresp(lsu_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit model_lsu_last;  // model: 1 when the LSU was the master served last

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m"}, 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 32'd0);
    check({tag, "_up"}, 32'({ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                             lsu_awready, lsu_wready, lsu_bvalid}), 32'd0);
  endtask

  task automatic ar_phase(input bit lsu, input logic [31:0] addr);
    int idle;
    bit done;
    idle = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      m_arready = (i > 5) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (m_arvalid) begin
        check("ar_id", 32'(m_arid), lsu ? 32'd1 : 32'd0);
        check("ar_addr", m_araddr, addr);
        check("ar_ready", 32'(lsu ? lsu_arready : ifu_arready), 32'(m_arready));
        check("ar_other", 32'({lsu ? ifu_arready : lsu_arready, m_awvalid, m_wvalid,
                               ifu_rvalid, lsu_rvalid}), 32'd0);
        done = m_arready;
      end else begin
        idle++;
      end
      step();
    end
    check("ar_latency", 32'(idle), 32'd1);
    check("ar_fire", 32'(done), 32'd1);
    if (lsu) lsu_arvalid = 1'b0;
    else     ifu_arvalid = 1'b0;
    m_arready = 1'b0;
  endtask

  task automatic r_phase(input bit lsu, input int nb, input int resp, input logic [31:0] d0);
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      logic [1:0]  rs;
      logic        rr;
      bit          fired;
      fired    = 1'b0;
      d        = (b == 0) ? d0 : $urandom;
      rs       = (resp < 0) ? 2'($urandom_range(0, 3)) : 2'(resp);
      m_rvalid = 1'b1;
      m_rdata  = d;
      m_rresp  = rs;
      m_rlast  = (b == nb - 1);
      m_rid    = 4'($urandom);
      for (int t = 0; t < 20 && !fired; t++) begin
        rr = (t > 3) ? 1'b1 : 1'($urandom_range(0, 1));
        if (lsu) begin lsu_rready = rr; ifu_rready = 1'($urandom_range(0, 1)); end
        else     begin ifu_rready = rr; lsu_rready = 1'($urandom_range(0, 1)); end
        #1;
        check("r_valid", 32'(lsu ? lsu_rvalid : ifu_rvalid), 32'd1);
        check("r_data", lsu ? lsu_rdata : ifu_rdata, d);
        check("r_resp", 32'(lsu ? lsu_rresp : ifu_rresp), 32'(rs));
        check("r_last", 32'(lsu ? lsu_rlast : ifu_rlast), (b == nb - 1) ? 32'd1 : 32'd0);
        check("r_ready", 32'(m_rready), 32'(rr));
        check("r_hold", 32'({lsu ? ifu_rvalid : lsu_rvalid, m_arvalid, m_awvalid, m_wvalid,
                             ifu_arready, lsu_arready}), 32'd0);
        fired = rr;
        step();
      end
      check("r_fire", 32'(fired), 32'd1);
    end
    m_rvalid   = 1'b0;
    m_rlast    = 1'b0;
    ifu_rready = 1'b0;
    lsu_rready = 1'b0;
  endtask

  task automatic w_phase(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int aw_at, input int w_at);
    int idle;
    bit aw_ok, w_ok, seen, awf, wf;
    idle  = 0;
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 30 && !(aw_ok && w_ok); i++) begin
      m_awready = (aw_at >= 0) ? (i == aw_at) : ((i > 6) ? 1'b1 : 1'($urandom_range(0, 1)));
      m_wready  = (w_at >= 0)  ? (i == w_at)  : ((i > 6) ? 1'b1 : 1'($urandom_range(0, 1)));
      #1;
      awf = 1'b0;
      wf  = 1'b0;
      if (seen || m_awvalid || m_wvalid) begin
        seen = 1'b1;
        check("aw_valid", 32'(m_awvalid), 32'(!aw_ok));
        check("w_valid", 32'(m_wvalid), 32'(!w_ok));
        check("wr_other", 32'({m_arvalid, ifu_arready, lsu_arready, lsu_bvalid, m_bready,
                               ifu_rvalid, lsu_rvalid}), 32'd0);
        if (!aw_ok) begin
          check("aw_addr", m_awaddr, addr);
          check("aw_ready", 32'(lsu_awready), 32'(m_awready));
        end
        if (!w_ok) begin
          check("w_data", m_wdata, data);
          check("w_strb", 32'(m_wstrb), 32'(strb));
          check("w_ready", 32'(lsu_wready), 32'(m_wready));
        end
        awf = !aw_ok && m_awready;
        wf  = !w_ok && m_wready;
      end else begin
        idle++;
      end
      step();
      if (awf) aw_ok = 1'b1;
      if (wf)  w_ok  = 1'b1;
    end
    check("wr_latency", 32'(idle), 32'd1);
    check("wr_fires", 32'({aw_ok, w_ok}), 32'd3);
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    m_awready   = 1'b0;
    m_wready    = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] resp);
    bit   fired;
    logic br;
    fired    = 1'b0;
    m_bvalid = 1'b1;
    m_bresp  = resp;
    for (int t = 0; t < 20 && !fired; t++) begin
      br = (t > 3) ? 1'b1 : 1'($urandom_range(0, 1));
      lsu_bready = br;
      #1;
      check("b_valid", 32'(lsu_bvalid), 32'd1);
      check("b_resp", 32'(lsu_bresp), 32'(resp));
      check("b_ready", 32'(m_bready), 32'(br));
      check("b_other", 32'({m_awvalid, m_wvalid, m_arvalid, ifu_rvalid, lsu_rvalid,
                            lsu_awready, lsu_wready}), 32'd0);
      fired = br;
      step();
    end
    check("b_fire", 32'(fired), 32'd1);
    m_bvalid   = 1'b0;
    lsu_bready = 1'b0;
  endtask

  // All requests of a round are raised together; the model replays the service order.
  task automatic run_round(input int n_ifu, input bit lr, input bit lw, input int nb, input int resp,
                           input logic [31:0] ia, input logic [31:0] id0,
                           input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                           input int aw_at, input int w_at, input logic [1:0] bresp);
    int          pend_i;
    bit          pend_lr, pend_lw;
    logic [31:0] la;
    pend_i  = n_ifu;
    pend_lr = lr;
    pend_lw = lw;
    la      = $urandom;
    ifu_arvalid = (n_ifu > 0);
    ifu_araddr  = ia;
    lsu_arvalid = lr;
    lsu_araddr  = la;
    lsu_awvalid = lw;
    lsu_wvalid  = lw;
    lsu_awaddr  = wa;
    lsu_wdata   = wd;
    lsu_wstrb   = ws;
    while (pend_i > 0 || pend_lr || pend_lw) begin
      if (pend_i > 0 && (!(pend_lr || pend_lw) || model_lsu_last)) begin
        model_lsu_last = 1'b0;
        ar_phase(1'b0, ia);
        r_phase(1'b0, (nb > 0) ? nb : int'($urandom_range(1, 4)), resp, id0);
        pend_i--;
        if (pend_i > 0) begin
          ia          = $urandom;
          id0         = $urandom;
          ifu_araddr  = ia;
          ifu_arvalid = 1'b1;
        end
      end else begin
        model_lsu_last = 1'b1;
        if (pend_lw) begin
          w_phase(wa, wd, ws, aw_at, w_at);
          b_phase(bresp);
          pend_lw = 1'b0;
        end else begin
          ar_phase(1'b1, la);
          r_phase(1'b1, (nb > 0) ? nb : int'($urandom_range(1, 4)), resp, $urandom);
          pend_lr = 1'b0;
        end
      end
    end
    #1;
    check_quiet("round_end");
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready} = '0;
    ifu_araddr = '0; lsu_araddr = '0; lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid} = '0;
    m_rdata = '0; m_rresp = '0; m_rid = '0; m_bresp = '0;
    model_lsu_last = 1'b1;
    repeat (3) step();
    check_quiet("reset");
    rst_n = 1'b1;

    // IFU alone, single beat
    run_round(1, 0, 0, 1, 0, 32'h8000_0000, 32'h0000_0413, 32'h0, 32'h0, 4'h0, -1, -1, 2'b00);
    // collision: IFU then LSU, then alternation with IFU re-requesting
    run_round(1, 1, 0, 1, -1, $urandom, $urandom, 32'h0, 32'h0, 4'h0, -1, -1, 2'b00);
    run_round(2, 1, 0, 1, -1, $urandom, $urandom, 32'h0, 32'h0, 4'h0, -1, -1, 2'b00);
    // LSU write beats LSU read; AW/W orderings
    run_round(0, 1, 1, 1, -1, 32'h0, 32'h0, 32'h1000_0000, 32'h41, 4'b0001, 1, 3, 2'b00);
    run_round(0, 1, 1, 1, -1, 32'h0, 32'h0, 32'h1000_0000, 32'h41, 4'b0001, 3, 1, 2'b00);
    run_round(0, 0, 1, 1, -1, 32'h0, 32'h0, 32'h1000_0004, 32'h42, 4'b0010, 1, 1, 2'b00);
    // 4-beat IFU burst while LSU waits
    run_round(1, 1, 0, 4, -1, $urandom, $urandom, 32'h0, 32'h0, 4'h0, -1, -1, 2'b00);
    // decode error forwarded on LSU read
    run_round(0, 1, 0, 1, 3, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, -1, -1, 2'b00);

    // reset in the middle of LSU_R
    lsu_arvalid = 1'b1;
    lsu_araddr  = 32'h2000_0000;
    ar_phase(1'b1, 32'h2000_0000);
    m_rvalid = 1'b1; m_rdata = 32'hdead_beef; m_rlast = 1'b1; lsu_rready = 1'b0;
    #1;
    check("rst_pre_rvalid", 32'(lsu_rvalid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    lsu_rready = 1'b1;
    #1;
    check_quiet("rst_mid");
    m_rvalid = 1'b0; m_rlast = 1'b0; lsu_rready = 1'b0;
    model_lsu_last = 1'b1;
    step();
    run_round(1, 1, 0, 1, -1, $urandom, $urandom, 32'h0, 32'h0, 4'h0, -1, -1, 2'b00);

    for (int r = 0; r < 40; r++) begin
      int n_i;
      bit lr, lw;
      n_i = $urandom_range(0, 2);
      lr  = 1'($urandom_range(0, 1));
      lw  = 1'($urandom_range(0, 1));
      if (n_i == 0 && !lr && !lw) n_i = 1;
      run_round(n_i, lr, lw, 0, -1, $urandom, $urandom, $urandom, $urandom, 4'($urandom),
                -1, -1, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040109_axi_arbiter.md
Name: ysyx_25040109_axi_arbiter

Overview:
- Two-master to one-slave AXI arbiter between the IFU (read-only) and the LSU (read and write) on one side, and the single upstream port of the address-decoding crossbar on the other.
- Exactly one transaction is outstanding at a time.
- The grant is locked from the address handshake until the final R beat (rlast) or the B handshake.
- Round-robin between IFU and LSU gives fetch/load fairness. Within the LSU, a pending write wins over a pending read.

Parameters:
- IFU_ID, 4'd0, arid driven for IFU reads.
- LSU_ID, 4'd1, arid driven for LSU reads.
- FIRST_PRIO_LSU, 1'b0, initial round-robin favourite after reset (0 = IFU).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- ifu_arvalid/ifu_arready  in/out  1  IFU AR handshake
- ifu_araddr  in  32  IFU read address
- ifu_rvalid/ifu_rready  out/in  1  IFU R handshake
- ifu_rdata  out  32  read data
- ifu_rresp  out  2  read response
- ifu_rlast  out  1  last beat
- lsu_arvalid/lsu_arready, lsu_araddr, lsu_rvalid/lsu_rready, lsu_rdata, lsu_rresp, lsu_rlast: same widths as the IFU set, for LSU reads.
- lsu_awvalid/lsu_awready  in/out  1; lsu_awaddr  in  32
- lsu_wvalid/lsu_wready  in/out  1; lsu_wdata  in  32; lsu_wstrb  in  4
- lsu_bvalid/lsu_bready  out/in  1; lsu_bresp  out  2
- m_arvalid out 1, m_arready in 1, m_araddr out 32, m_arid out 4
- m_rvalid in 1, m_rready out 1, m_rdata in 32, m_rresp in 2, m_rid in 4, m_rlast in 1
- m_awvalid out 1, m_awready in 1, m_awaddr out 32
- m_wvalid out 1, m_wready in 1, m_wdata out 32, m_wstrb out 4
- m_bvalid in 1, m_bready out 1, m_bresp in 2

Behaviour:
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_WR, LSU_B.
- Reset (rst_n=0 at clk edge):
  - state=IDLE, rr_last=~FIRST_PRIO_LSU, aw_done=w_done=0.
  - All m_* valids and all upstream readys/valids are 0.
  - Reset mid-transaction abandons it immediately; no B or R is delivered.
- IDLE decision (registered):
  - lsu_req = lsu_awvalid | lsu_arvalid.
  - If ifu_arvalid and lsu_req both assert, grant the master not served last (rr_last).
  - If only one requests, grant that one.
  - An LSU grant goes to LSU_WR when lsu_awvalid=1, otherwise to LSU_AR.
  - rr_last is updated on grant.
  - Latency: request seen in cycle N gives m_*valid in cycle N+1. All upstream readys are 0 in IDLE.
- IFU_AR / LSU_AR:
  - m_arvalid = granted arvalid; m_araddr = granted araddr; m_arid = IFU_ID or LSU_ID.
  - Granted arready = m_arready.
  - On m_ar fire, move to the matching _R state.
  - If the master drops arvalid before the fire, return to IDLE (protocol tolerance).
- IFU_R / LSU_R:
  - Granted rvalid = m_rvalid; granted rready drives m_rready.
  - rdata, rresp and rlast pass through; m_rid is ignored for routing.
  - The non-granted master sees rvalid=0.
  - On an R fire with m_rlast=1, return to IDLE.
- LSU_WR:
  - m_awvalid = lsu_awvalid & ~aw_done; m_wvalid = lsu_wvalid & ~w_done.
  - AW and W may fire in the same or in different cycles. Each fire sets its done flag.
  - Move to LSU_B in the cycle after both flags are set, or both fires occur together.
- LSU_B:
  - lsu_bvalid = m_bvalid; m_bready = lsu_bready; bresp passes through.
  - On a B fire, clear the done flags and return to IDLE.
- Idle channels:
  - Unused m_ addr/data outputs carry don't-care values; drive them with the LSU/IFU mux.
  - Unused valids are strictly 0.
- Simultaneous events:
  - New requests arriving while busy wait; no queueing beyond the master holding valid.
  - A request that arrives on the same edge a transaction completes is evaluated in the following IDLE cycle (one bubble cycle between transactions).

Test Plan:
- IFU alone: arvalid, araddr=0x80000000; m_arready=1; one beat rdata=0x00000413, rlast=1 -> m_arvalid in cycle 1 with m_arid=0; ifu_rdata=0x00000413; state back to IDLE; lsu_rvalid stays 0.
- IFU and LSU read asserted together after reset (FIRST_PRIO_LSU=0) -> IFU served first, then LSU with m_arid=1. Repeat the collision -> LSU first, then IFU (alternation).
- LSU aw and ar both valid, awaddr=0x10000000, wdata=0x41, wstrb=4'b0001 -> write is issued first. Both orders of AW and W fire (m_awready=1 cycle 1, m_wready=1 cycle 3) reach LSU_B. bresp=2'b00 is delivered; the read follows.
- Burst read of 4 beats with rlast only on beat 4, IFU rready toggling -> all 4 beats are forwarded in order; grant is held; LSU request waits until after beat 4.
- Decode error: m_rresp=2'b11 on the LSU read -> lsu_rresp=2'b11 is forwarded; arbiter returns to IDLE normally.
- rst_n=0 during LSU_R -> next cycle all valids and readys are 0, state IDLE; a fresh IFU request is then granted normally.
